// File: rtl/alu_muldiv_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers and R-type funct decode.
// Define MULDIV_DIV_EN to compile in div/divu decode and the restoring divider.
module alu_muldiv_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [2:0]       ALUOp_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             ready_o,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             rd_valid_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CntW = $clog2(WIDTH);

   localparam logic [5:0] FnMfhi  = 6'b010000;
   localparam logic [5:0] FnMthi  = 6'b010001;
   localparam logic [5:0] FnMflo  = 6'b010010;
   localparam logic [5:0] FnMtlo  = 6'b010011;
   localparam logic [5:0] FnMult  = 6'b011000;
   localparam logic [5:0] FnMultu = 6'b011001;
`ifdef MULDIV_DIV_EN
   localparam logic [5:0] FnDiv   = 6'b011010;
   localparam logic [5:0] FnDivu  = 6'b011011;
`endif

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic                 lo_neg_q, lo_neg_d;
   logic                 hi_neg_q, hi_neg_d;
   logic                 is_div_q, is_div_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   logic dec_en;
   logic is_mfhi, is_mthi, is_mflo, is_mtlo, is_mult, is_multu, is_div, is_divu;
   logic any_op, ready, start_mul, start_div;
   logic signed_op, s1_neg, s2_neg;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign dec_en   = valid_i && (ALUOp_i == 3'b000);
   assign is_mfhi  = dec_en && (funct_i == FnMfhi);
   assign is_mthi  = dec_en && (funct_i == FnMthi);
   assign is_mflo  = dec_en && (funct_i == FnMflo);
   assign is_mtlo  = dec_en && (funct_i == FnMtlo);
   assign is_mult  = dec_en && (funct_i == FnMult);
   assign is_multu = dec_en && (funct_i == FnMultu);
`ifdef MULDIV_DIV_EN
   assign is_div   = dec_en && (funct_i == FnDiv);
   assign is_divu  = dec_en && (funct_i == FnDivu);
`else
   assign is_div   = 1'b0;
   assign is_divu  = 1'b0;
`endif

   assign any_op    = is_mfhi | is_mthi | is_mflo | is_mtlo |
                      is_mult | is_multu | is_div | is_divu;
   assign ready     = (state_q == StIdle);
   assign start_mul = ready & (is_mult | is_multu);
   assign start_div = ready & (is_div | is_divu);

   // Operands are reduced to magnitudes; signs are reapplied in StFix.
   assign signed_op = is_mult | is_div;
   assign s1_neg    = signed_op & src1_i[WIDTH-1];
   assign s2_neg    = signed_op & src2_i[WIDTH-1];
   assign mag1      = s1_neg ? -src1_i : src1_i;
   assign mag2      = s2_neg ? -src2_i : src2_i;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign prod_fix = lo_neg_q ? -acc_q : acc_q;
   assign quo_fix  = lo_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = hi_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_DIV_EN
   logic [WIDTH:0] div_shift, div_diff;
   logic           div_ge;

   // Borrow-free subtraction means the shifted remainder covers the divisor.
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_ge    = ~div_diff[WIDTH];
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      lo_neg_d = lo_neg_q;
      hi_neg_d = hi_neg_q;
      is_div_d = is_div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_mul) begin
               state_d  = StMul;
               cnt_d    = CntW'(WIDTH - 1);
               acc_d    = {{WIDTH{1'b0}}, mag2};
               opb_d    = mag1;
               lo_neg_d = s1_neg ^ s2_neg;
               hi_neg_d = s1_neg ^ s2_neg;
               is_div_d = 1'b0;
            end else if (start_div) begin
               state_d  = StDiv;
               cnt_d    = CntW'(WIDTH - 1);
               acc_d    = {{WIDTH{1'b0}}, mag1};
               opb_d    = mag2;
               // Divide by zero keeps the all-ones quotient un-negated.
               lo_neg_d = (s1_neg ^ s2_neg) & (|src2_i);
               hi_neg_d = s1_neg;
               is_div_d = 1'b1;
            end else if (is_mthi) begin
               hi_d = src1_i;
            end else if (is_mtlo) begin
               lo_d = src1_i;
            end
         end
         StMul: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            if (cnt_q == '0) state_d = StFix;
            else             cnt_d   = cnt_q - CntW'(1);
         end
`ifdef MULDIV_DIV_EN
         StDiv: begin
            acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
            if (cnt_q == '0) state_d = StFix;
            else             cnt_d   = cnt_q - CntW'(1);
         end
`endif
         StFix: begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (is_div_q) begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         lo_neg_q <= 1'b0;
         hi_neg_q <= 1'b0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         lo_neg_q <= lo_neg_d;
         hi_neg_q <= hi_neg_d;
         is_div_q <= is_div_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign ready_o    = ready;
   assign done_o     = done_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign stall_o    = any_op & ~ready;
   assign rd_valid_o = ready & (is_mfhi | is_mflo);
   assign result_o   = (ready & is_mfhi) ? hi_q :
                       (ready & is_mflo) ? lo_q : '0;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench for alu_muldiv_ctrl; expected HI/LO come from a scoreboard queue.
// Div checks follow MULDIV_DIV_EN, matching the build of the design.
module tb_alu_muldiv_ctrl;

   localparam logic [5:0] FMfhi  = 6'b010000;
   localparam logic [5:0] FMthi  = 6'b010001;
   localparam logic [5:0] FMflo  = 6'b010010;
   localparam logic [5:0] FMtlo  = 6'b010011;
   localparam logic [5:0] FMult  = 6'b011000;
   localparam logic [5:0] FMultu = 6'b011001;
   localparam logic [5:0] FDiv   = 6'b011010;
   localparam logic [5:0] FDivu  = 6'b011011;
   localparam logic [5:0] FAddu  = 6'b100001;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [2:0]  ALUOp_i = 3'b000;
   logic [5:0]  funct_i = 6'b0;
   logic [31:0] src1_i = '0;
   logic [31:0] src2_i = '0;
   logic        ready_o, stall_o, done_o, rd_valid_o;
   logic [31:0] result_o, hi_o, lo_o;

   int total = 0;
   int bad = 0;
   logic [63:0] sb_q[$];

   alu_muldiv_ctrl #(.WIDTH(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .ALUOp_i    (ALUOp_i),
      .funct_i    (funct_i),
      .src1_i     (src1_i),
      .src2_i     (src2_i),
      .ready_o    (ready_o),
      .stall_o    (stall_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .rd_valid_o (rd_valid_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns {hi, lo}.
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, m;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      if (f == FMult) begin
         r = sa * sb;
      end else if (f == FMultu) begin
         r = {32'h0, a} * {32'h0, b};
      end else if (b == 32'h0) begin
         r = {a, 32'hFFFF_FFFF};
      end else if (f == FDiv) begin
         q = sa / sb;
         m = sa % sb;
         r = {m[31:0], q[31:0]};
      end else begin
         r = {a % b, a / b};
      end
      return r;
   endfunction

   // Call at a negedge with the unit idle; returns at the negedge after the accept edge.
   task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      valid_i = 1'b1;
      funct_i = f;
      src1_i  = a;
      src2_i  = b;
      sb_q.push_back(model(f, a, b));
      @(negedge clk_i);
      valid_i = 1'b0;
      src1_i  = $urandom;
      src2_i  = $urandom;
   endtask

   task automatic wait_done(input string tag);
      int cyc;
      logic [63:0] exp;
      cyc = 0;
      while (done_o !== 1'b1 && cyc < 40) begin
         @(negedge clk_i);
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'd33);
      if (done_o === 1'b1 && sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         chk({tag, "_hi"}, 64'(hi_o), 64'(exp[63:32]));
         chk({tag, "_lo"}, 64'(lo_o), 64'(exp[31:0]));
         chk({tag, "_ready"}, 64'(ready_o), 64'd1);
      end
   endtask

   initial begin
      int cyc;
      logic [63:0] exp;

      #2;
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_rdvalid", 64'(rd_valid_o), 64'd0);
      chk("rst_result", 64'(result_o), 64'd0);
      chk("rst_hilo", {32'(hi_o), 32'(lo_o)}, 64'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);

      // Signed mult, then multu issued in the done cycle.
      start_op(FMult, 32'hFFFF_FFFF, 32'd2);
      chk("mult_busy", 64'(ready_o), 64'd0);
      wait_done("mult");
      chk("mult_hi_const", 64'(hi_o), 64'hFFFF_FFFF);
      chk("mult_lo_const", 64'(lo_o), 64'hFFFF_FFFE);
      start_op(FMultu, 32'hFFFF_FFFF, 32'd2);
      chk("b2b_accept", 64'(ready_o), 64'd0);

      // addu during busy must not stall; mflo from cycle 5 stalls until done.
      cyc = 0;
      while (cyc < 40) begin
         if (cyc == 2) begin
            valid_i = 1'b1;
            funct_i = FAddu;
         end else if (cyc >= 5) begin
            valid_i = 1'b1;
            funct_i = FMflo;
         end else begin
            valid_i = 1'b0;
         end
         #1;
         if (done_o === 1'b1) break;
         if (cyc == 2) chk("addu_nostall", 64'(stall_o), 64'd0);
         if (cyc == 9) begin
            chk("mflo_stall", 64'(stall_o), 64'd1);
            chk("mflo_busy_rdvalid", 64'(rd_valid_o), 64'd0);
            chk("mflo_busy_result", 64'(result_o), 64'd0);
         end
         @(negedge clk_i);
         cyc++;
      end
      chk("multu_latency", 64'(cyc), 64'd33);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'h0;
      chk("multu_hi", 64'(hi_o), 64'(exp[63:32]));
      chk("multu_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFE);
      chk("mflo_result", 64'(result_o), 64'(exp[31:0]));
      chk("mflo_rdvalid", 64'(rd_valid_o), 64'd1);
      chk("mflo_nostall", 64'(stall_o), 64'd0);
      @(negedge clk_i);
      valid_i = 1'b0;

      // Non-R-type op class is ignored.
      valid_i = 1'b1;
      ALUOp_i = 3'b001;
      funct_i = FMult;
      #1;
      chk("aluop_nostall", 64'(stall_o), 64'd0);
      @(negedge clk_i);
      valid_i = 1'b0;
      ALUOp_i = 3'b000;
      chk("aluop_ignored", 64'(ready_o), 64'd1);

      // Moves in idle.
      valid_i = 1'b1;
      funct_i = FMthi;
      src1_i  = 32'h1234;
      #1;
      chk("mthi_nostall", 64'(stall_o), 64'd0);
      @(negedge clk_i);
      funct_i = FMfhi;
      #1;
      chk("mfhi_result", 64'(result_o), 64'h1234);
      chk("mfhi_rdvalid", 64'(rd_valid_o), 64'd1);
      chk("mfhi_nostall", 64'(stall_o), 64'd0);
      funct_i = FMtlo;
      src1_i  = 32'h5678;
      @(negedge clk_i);
      funct_i = FMflo;
      #1;
      chk("mflo_idle_result", 64'(result_o), 64'h5678);
      @(negedge clk_i);
      valid_i = 1'b0;

      for (int i = 0; i < 4; i++) begin
         start_op((i % 2 == 0) ? FMult : FMultu, $urandom, $urandom);
         wait_done("rand_mul");
      end
      start_op(FMult, 32'h8000_0000, 32'h8000_0000);
      wait_done("mult_minmin");

`ifdef MULDIV_DIV_EN
      start_op(FDiv, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_m7_2");
      chk("div_m7_2_lo_const", 64'(lo_o), 64'hFFFF_FFFD);
      start_op(FDivu, 32'd7, 32'd0);
      wait_done("divu_by0");
      chk("divu_by0_hi_const", 64'(hi_o), 64'd7);
      start_op(FDiv, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_min_m1");
      start_op(FDiv, 32'hFFFF_FFF9, 32'd0);
      wait_done("div_by0_neg");
      start_op(FDivu, 32'hFFFF_FFF9, 32'd3);
      wait_done("divu_big");
      start_op(FDiv, 32'd100, 32'hFFFF_FFF9);
      wait_done("div_pos_neg");
`else
      valid_i = 1'b1;
      funct_i = FMthi;
      src1_i  = 32'hAAAA;
      @(negedge clk_i);
      funct_i = FMtlo;
      src1_i  = 32'h5555;
      @(negedge clk_i);
      funct_i = FDiv;
      src1_i  = 32'hFFFF_FFF9;
      src2_i  = 32'd2;
      #1;
      chk("nodiv_nostall", 64'(stall_o), 64'd0);
      @(negedge clk_i);
      valid_i = 1'b0;
      chk("nodiv_ready", 64'(ready_o), 64'd1);
      @(negedge clk_i);
      chk("nodiv_hilo", {32'(hi_o), 32'(lo_o)}, {32'hAAAA, 32'h5555});
      chk("nodiv_nodone", 64'(done_o), 64'd0);
`endif

      // Asynchronous reset mid-operation.
      start_op(FMult, 32'd12345, 32'd678);
      repeat (9) @(negedge clk_i);
      #2;
      rst_i = 1'b0;
      #1;
      chk("arst_hilo", {32'(hi_o), 32'(lo_o)}, 64'd0);
      chk("arst_ready", 64'(ready_o), 64'd1);
      chk("arst_done", 64'(done_o), 64'd0);
      void'(sb_q.pop_back());
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (40) begin
         @(negedge clk_i);
         if (done_o !== 1'b0) break;
      end
      chk("arst_no_done", 64'(done_o), 64'd0);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
